// File: rtl/ctrl_stage_pipe.sv
// Control-bundle pipeline from ID through WB: one register per stage, with bubble
// insertion, global freeze, per-stage flush, per-stage valid bits and a bubble counter.
module ctrl_stage_pipe #(
  parameter int unsigned       CTRL_W    = 10,
  parameter int unsigned       STAGES    = 3,
  parameter logic [CTRL_W-1:0] NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CTRL_W-1:0]        ctrl_i,
  input  logic                     valid_i,
  input  logic                     bubble_i,
  input  logic                     freeze_i,
  input  logic [STAGES-1:0]        flush_i,
  input  logic                     cnt_clr_i,
  output logic [STAGES*CTRL_W-1:0] ctrl_o,
  output logic [STAGES-1:0]        valid_o,
  output logic [CNT_W-1:0]         bubble_cnt_o
);

  logic [CTRL_W-1:0] word_q [STAGES];
  logic [CTRL_W-1:0] word_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cnt_event;
  logic              cnt_sat;

  // Stage next-state: flush beats freeze, freeze beats advance.
  always_comb begin : stage_next
    for (int unsigned k = 0; k < STAGES; k++) begin
      word_d[k]  = word_q[k];
      valid_d[k] = valid_q[k];
    end

    if (!freeze_i) begin
      word_d[0]  = bubble_i ? NOP_VALUE : ctrl_i;
      valid_d[0] = valid_i & ~bubble_i;
      for (int unsigned k = 1; k < STAGES; k++) begin
        word_d[k]  = word_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end

    for (int unsigned k = 0; k < STAGES; k++) begin
      if (flush_i[k]) begin
        word_d[k]  = NOP_VALUE;
        valid_d[k] = 1'b0;
      end
    end
  end

  // A bubble counts whenever stage 0 would have advanced, even if stage 0 is flushed.
  assign cnt_event = bubble_i & ~freeze_i;
  assign cnt_sat   = &cnt_q;

  always_comb begin : cnt_next
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_event && !cnt_sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        word_q[k] <= NOP_VALUE;
      end
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        word_q[k] <= word_d[k];
      end
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : gen_out
    assign ctrl_o[g*CTRL_W +: CTRL_W] = word_q[g];
  end

  assign valid_o      = valid_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_ctrl_stage_pipe.sv
// Bench for ctrl_stage_pipe: directed scenarios plus randomized traffic against a
// queue-style reference model; a one-stage build with a non-zero NOP runs alongside.
module tb_ctrl_stage_pipe;

  localparam int unsigned W    = 10;
  localparam int unsigned S    = 3;
  localparam logic [W-1:0] NOP  = 10'h000;
  localparam logic [W-1:0] NOP1 = 10'h155;

  logic           clk;
  logic           rst;
  logic [W-1:0]   ctrl;
  logic           vin;
  logic           bubble;
  logic           freeze;
  logic [S-1:0]   flush;
  logic           clr;
  logic [S*W-1:0] ctrl_o;
  logic [S-1:0]   valid_o;
  logic [3:0]     cnt_o;
  logic [W-1:0]   ctrl1_o;
  logic [0:0]     valid1_o;
  logic [3:0]     cnt1_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: main pipeline as an array ordered newest first.
  logic [W-1:0] m_word [S];
  logic [S-1:0] m_valid;
  int           m_cnt;
  logic [W-1:0] m1_word;
  logic         m1_valid;
  int           m1_cnt;

  ctrl_stage_pipe #(.CTRL_W(W), .STAGES(S), .NOP_VALUE(NOP), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .valid_i(vin), .bubble_i(bubble),
    .freeze_i(freeze), .flush_i(flush), .cnt_clr_i(clr), .ctrl_o(ctrl_o),
    .valid_o(valid_o), .bubble_cnt_o(cnt_o)
  );

  ctrl_stage_pipe #(.CTRL_W(W), .STAGES(1), .NOP_VALUE(NOP1), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .valid_i(vin), .bubble_i(bubble),
    .freeze_i(freeze), .flush_i(flush[0:0]), .cnt_clr_i(clr), .ctrl_o(ctrl1_o),
    .valid_o(valid1_o), .bubble_cnt_o(cnt1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [S*W-1:0] exp_ctrl();
    logic [S*W-1:0] r;
    for (int k = 0; k < S; k++) r[k*W +: W] = m_word[k];
    return r;
  endfunction

  function automatic logic [W-1:0] stage(input int k);
    return ctrl_o[k*W +: W];
  endfunction

  task automatic model_edge();
    logic [W-1:0] in_w;
    logic         in_v;
    if (rst) begin
      for (int k = 0; k < S; k++) m_word[k] = NOP;
      m_valid = '0;
      m_cnt   = 0;
      m1_word = NOP1;
      m1_valid = 1'b0;
      m1_cnt  = 0;
      return;
    end
    in_w = ctrl;
    in_v = vin;
    if (bubble) begin
      in_w = NOP;
      in_v = 1'b0;
    end
    if (!freeze) begin
      for (int k = S - 1; k > 0; k--) begin
        m_word[k]  = m_word[k-1];
        m_valid[k] = m_valid[k-1];
      end
      m_word[0]  = in_w;
      m_valid[0] = in_v;
      m1_word    = bubble ? NOP1 : ctrl;
      m1_valid   = in_v;
    end
    for (int k = 0; k < S; k++) begin
      if (flush[k]) begin
        m_word[k]  = NOP;
        m_valid[k] = 1'b0;
      end
    end
    if (flush[0]) begin
      m1_word  = NOP1;
      m1_valid = 1'b0;
    end
    if (clr) begin
      m_cnt  = 0;
      m1_cnt = 0;
    end else if (bubble && !freeze) begin
      m_cnt  = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
      m1_cnt = (m1_cnt + 1 > 15) ? 15 : m1_cnt + 1;
    end
  endtask

  task automatic drive(input logic [W-1:0] c, input logic v, input logic b, input logic f,
                       input logic [S-1:0] fl, input logic cl, input logic r);
    ctrl = c; vin = v; bubble = b; freeze = f; flush = fl; clr = cl; rst = r;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    drive(10'h000, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill(input logic [W-1:0] s2, input logic [W-1:0] s1, input logic [W-1:0] s0);
    drive(s2, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0); step();
    drive(s1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0); step();
    drive(s0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0); step();
    idle();
  endtask

  task automatic test_reset();
    drive(10'h3FF, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    step(); step();
    vectors++;
    if (ctrl_o !== {S*W{1'b0}}) begin
      miscompares++; $display("FAIL reset_ctrl got %h want %h", ctrl_o, {S*W{1'b0}});
    end
    vectors++;
    if (valid_o !== 3'b000) begin
      miscompares++; $display("FAIL reset_valid got %b want 000", valid_o);
    end
    vectors++;
    if (cnt_o !== 4'd0) begin
      miscompares++; $display("FAIL reset_cnt got %0d want 0", cnt_o);
    end
    vectors++;
    if (ctrl1_o !== NOP1 || valid1_o !== 1'b0 || cnt1_o !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_one_stage got %h/%b/%0d want %h/0/0", ctrl1_o, valid1_o, cnt1_o, NOP1);
    end
    idle();
  endtask

  task automatic test_flow();
    logic [W-1:0] seq [3] = '{10'h2A5, 10'h1C3, 10'h0F0};
    for (int e = 1; e <= 5; e++) begin
      if (e <= 3) drive(seq[e-1], 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      else drive(W'($urandom), 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      step();
      if (e >= 3) begin
        vectors++;
        if (stage(2) !== seq[e-3]) begin
          miscompares++; $display("FAIL flow_stage2_edge%0d got %h want %h", e, stage(2), seq[e-3]);
        end
        vectors++;
        if (valid_o !== 3'b111) begin
          miscompares++; $display("FAIL flow_valid_edge%0d got %b want 111", e, valid_o);
        end
      end
    end
    idle();
  endtask

  task automatic test_bubble();
    drive(10'h155, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0); step();
    drive(10'h3FF, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0); step();
    vectors++;
    if (stage(0) !== 10'h000 || valid_o[0] !== 1'b0) begin
      miscompares++; $display("FAIL bubble_stage0 got %h/%b want 000/0", stage(0), valid_o[0]);
    end
    drive(10'h0AA, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0); step(); step();
    vectors++;
    if (stage(2) !== 10'h000 || valid_o !== 3'b011) begin
      miscompares++; $display("FAIL bubble_stage2 got %h/%b want 000/011", stage(2), valid_o);
    end
    vectors++;
    if (cnt_o !== 4'd1) begin
      miscompares++; $display("FAIL bubble_cnt got %0d want 1", cnt_o);
    end
    idle();
  endtask

  task automatic test_freeze_flush();
    int c0;
    fill(10'h333, 10'h222, 10'h111);
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(W'($urandom), 1'b1, 1'b1, 1'b1, (i == 1) ? 3'b010 : 3'b000, 1'b0, 1'b0);
      step();
    end
    vectors++;
    if (stage(0) !== 10'h111 || stage(1) !== 10'h000 || stage(2) !== 10'h333) begin
      miscompares++; $display("FAIL freeze_words got %h want 333_000_111", ctrl_o);
    end
    vectors++;
    if (valid_o !== 3'b101) begin
      miscompares++; $display("FAIL freeze_valid got %b want 101", valid_o);
    end
    vectors++;
    if (cnt_o !== 4'(c0)) begin
      miscompares++; $display("FAIL freeze_cnt got %0d want %0d", cnt_o, c0);
    end
    idle();
  endtask

  task automatic test_squash();
    int c0;
    fill(10'h0C1, 10'h0B2, 10'h0A3);
    c0 = m_cnt;
    drive(10'h2F0, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0); step();
    vectors++;
    if (stage(0) !== 10'h000 || stage(1) !== 10'h000 || stage(2) !== 10'h0B2) begin
      miscompares++; $display("FAIL squash_words got %h want 0b2_000_000", ctrl_o);
    end
    vectors++;
    if (valid_o !== 3'b100) begin
      miscompares++; $display("FAIL squash_valid got %b want 100", valid_o);
    end
    vectors++;
    if (cnt_o !== 4'(c0 + 1)) begin
      miscompares++; $display("FAIL squash_cnt got %0d want %0d", cnt_o, c0 + 1);
    end
    idle();
  endtask

  task automatic test_saturation();
    drive(10'h000, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0); step();
    for (int i = 0; i < 20; i++) begin
      drive(W'($urandom), 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0); step();
      if (i == 14 || i == 19) begin
        vectors++;
        if (cnt_o !== 4'd15) begin
          miscompares++; $display("FAIL sat_cnt_after_%0d got %0d want 15", i + 1, cnt_o);
        end
      end
    end
    drive(10'h000, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0); step();
    vectors++;
    if (cnt_o !== 4'd0 || cnt1_o !== 4'd0) begin
      miscompares++; $display("FAIL clr_vs_bubble got %0d/%0d want 0/0", cnt_o, cnt1_o);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    drive(10'h000, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0); step();
    fill(10'h1E1, 10'h1D2, 10'h1C3);
    drive(10'h3A3, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1); step();
    vectors++;
    if (ctrl_o !== {S*W{1'b0}} || valid_o !== 3'b000 || cnt_o !== 4'd0) begin
      miscompares++; $display("FAIL mid_reset got %h/%b/%0d want 0/000/0", ctrl_o, valid_o, cnt_o);
    end
    drive(10'h3A3, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0); step();
    vectors++;
    if (stage(0) !== 10'h3A3 || valid_o !== 3'b001) begin
      miscompares++; $display("FAIL resume got %h/%b want 3a3/001", stage(0), valid_o);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(W'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) == 0),
            ($urandom_range(4) == 0),
            {($urandom_range(7) == 0), ($urandom_range(7) == 0), ($urandom_range(7) == 0)},
            ($urandom_range(29) == 0), ($urandom_range(49) == 0));
      step();
      vectors++;
      if (ctrl_o !== exp_ctrl() || valid_o !== m_valid || cnt_o !== 4'(m_cnt)) begin
        miscompares++;
        $display("FAIL random_%0d got %h/%b/%0d want %h/%b/%0d", i, ctrl_o, valid_o, cnt_o,
                 exp_ctrl(), m_valid, m_cnt);
      end
      vectors++;
      if (ctrl1_o !== m1_word || valid1_o[0] !== m1_valid || cnt1_o !== 4'(m1_cnt)) begin
        miscompares++;
        $display("FAIL random_one_stage_%0d got %h/%b/%0d want %h/%b/%0d", i, ctrl1_o,
                 valid1_o, cnt1_o, m1_word, m1_valid, m1_cnt);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_flow();
    test_bubble();
    test_freeze_flush();
    test_squash();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_stage_pipe.md
Name: ctrl_stage_pipe

Overview:
- Parametrised control-bundle pipeline for the MIPS datapath.
- Carries the decoded control word from ID through EX/MEM/WB, one register stage per pipeline stage.
- Handles three hazard actions:
  - bubble insertion: load-use stall, replaces the incoming word with the NOP value;
  - global freeze: all stages hold;
  - per-stage flush: branch/jump squash.
- Provides per-stage valid bits and a saturating bubble counter for performance monitoring.

Parameters:
- CTRL_W, 10, width of one control bundle (RegDst, ALUSrc, MemToReg, RegWrite, MemWrite, Branch, Jump, ExtOp, ALUOp[1:0]).
- STAGES, 3, number of register stages (stage 0 = ID/EX, last = MEM/WB); legal range 1..8.
- NOP_VALUE, 0, CTRL_W-bit word loaded on bubble, flush and reset.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ctrl_i  in  CTRL_W  control word from the decoder.
- valid_i  in  1  ctrl_i carries a real instruction.
- bubble_i  in  1  load-use stall; insert NOP into stage 0 instead of ctrl_i.
- freeze_i  in  1  hold every stage (memory wait).
- flush_i  in  STAGES  bit k squashes stage k.
- cnt_clr_i  in  1  synchronous clear of bubble_cnt_o.
- ctrl_o  out  STAGES*CTRL_W  stage k occupies bits [k*CTRL_W +: CTRL_W].
- valid_o  out  STAGES  bit k = stage k holds a live instruction.
- bubble_cnt_o  out  CNT_W  count of bubbles inserted.

Behaviour:
- Reset:
  - Every stage word = NOP_VALUE.
  - valid_o = 0.
  - bubble_cnt_o = 0.
  - All outputs are registered; no combinational path from any input to any output.
- Per-stage update priority for stage k, highest first:
  1. rst_i;
  2. flush_i[k];
  3. freeze_i;
  4. advance.
- Flush:
  - Stage k word becomes NOP_VALUE and valid_o[k] becomes 0 on the next edge.
  - Applies even while freeze_i=1.
  - Multiple flush bits may be set together; each flushed stage clears independently.
- Freeze: every non-flushed stage keeps its word and valid bit. bubble_i, ctrl_i and valid_i are ignored.
- Advance, stage 0:
  - If bubble_i=1, word = NOP_VALUE and valid = 0.
  - Otherwise word = ctrl_i and valid = valid_i.
- Advance, stage k>0: word and valid are copied from stage k-1 as they were before the edge.
- Invalid entries: if valid_i=0 and bubble_i=0, stage 0 still captures ctrl_i unmodified, with valid = 0. Consumers must gate on valid_o.
- Latency: a word accepted at edge n appears on stage k at edge n+k, in the absence of freeze and flush.
- Bubble counter:
  - Increments by 1 on each edge where bubble_i=1, freeze_i=0 and rst_i=0.
  - A bubble that coincides with flush_i[0] still counts.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - cnt_clr_i forces 0. If cnt_clr_i and a count event coincide, the result is 0.
- Reset mid-operation: all in-flight words are discarded on the same edge; there is no drain.
- A STAGES=1 build must work; stage 0 is then also the last stage.

Test Plan:
- Reset release then straight-line flow: with STAGES=3, apply ctrl_i=0x2A5, 0x1C3, 0x0F0 on three consecutive cycles with valid_i=1 → ctrl_o stage 2 shows 0x2A5 on edge 3, 0x1C3 on edge 4, 0x0F0 on edge 5; all valid_o bits = 1 from edge 3.
- Load-use bubble: bubble_i=1 for one cycle while ctrl_i=0x3FF → stage 0 = 0x000 with valid 0; the bubble propagates to stage 2 two edges later; bubble_cnt_o = 1.
- Freeze with flush: pipeline full (stages = 0x111, 0x222, 0x333), freeze_i=1 for 3 cycles with flush_i=3'b010 on the 2nd cycle → stages 0 and 2 unchanged; stage 1 becomes 0x000 with valid 0; no bubble is counted even though bubble_i=1 throughout.
- Branch squash: flush_i=3'b011 together with bubble_i=1 → stages 0 and 1 are NOP and invalid; stage 2 receives the old stage 1 content; bubble_cnt_o increments.
- Counter saturation and clear: with CNT_W=4, apply 20 bubbles → bubble_cnt_o holds at 15; then cnt_clr_i and bubble_i asserted together → 0.
- Mid-stream reset: with a full pipeline, pulse rst_i for one cycle → on the next edge all words = NOP_VALUE, valid_o = 0 and the counter = 0; the flow resumes normally the cycle after.
